// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Holds register-address constants, the default pipeline depth, and the
// scoreboard slot type used by the hazard unit and its match sub-module.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int NUM_PIPE_SLOTS = 3;

  // One in-flight register write: valid flag plus destination address.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
  } sb_slot_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational compare of one source register against every scoreboard slot.
// Ports:
//   slots - scoreboard contents, index 0 = EX
//   addr  - source register address being read in ID
//   hit   - 1 when addr is non-zero and some valid slot targets it
module hazard_match
  import mips_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_PIPE_SLOTS
) (
  input  sb_slot_t [NUM_SLOTS-1:0]  slots,
  input  logic     [REG_ADDR_W-1:0] addr,
  output logic                      hit
);

  logic any_hit;

  always_comb begin
    any_hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slots[i].valid && (slots[i].addr == addr)) begin
        any_hit = 1'b1;
      end
    end
  end

  // $0 is hardwired, so it can never be a real dependency.
  assign hit = any_hit & (addr != REG_ZERO);

endmodule

// File: rtl/hazard_unit.sv
// Scoreboard-based load/use and RAW hazard detector for a 5-stage MIPS.
// Tracks destination registers of instructions in EX/MEM/WB and stalls the
// ID instruction until every producer of a source it reads has left WB
// (the register file has no write-through bypass).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   id_valid        - ID holds a real instruction
//   id_rs, id_rt    - ID source registers
//   id_uses_rt      - ID instruction actually reads rt
//   id_regwr, id_aw - ID instruction writes register id_aw
//   flush           - kill ID instruction this cycle (wins over stall)
//   stall           - hold PC and IF/ID
//   bubble          - zero write-enables entering ID/EX
//   pending         - per-slot valid bits, bit 0 = EX
//   stall_cycles    - saturating count of stalled cycles
module hazard_unit
  import mips_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_PIPE_SLOTS,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_regwr,
  input  logic [REG_ADDR_W-1:0] id_aw,
  input  logic                  flush,
  output logic                  stall,
  output logic                  bubble,
  output logic [NUM_SLOTS-1:0]  pending,
  output logic [CNT_W-1:0]      stall_cycles
);

  sb_slot_t [NUM_SLOTS-1:0] slots;
  sb_slot_t                 new_slot;
  logic                     hit_rs;
  logic                     hit_rt;
  logic                     insert;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_match #(.NUM_SLOTS(NUM_SLOTS)) u_match_rs (
    .slots (slots),
    .addr  (id_rs),
    .hit   (hit_rs)
  );

  hazard_match #(.NUM_SLOTS(NUM_SLOTS)) u_match_rt (
    .slots (slots),
    .addr  (id_rt),
    .hit   (hit_rt)
  );

  // Hazard decision: flush and reset both override any match.
  assign stall  = id_valid & ~flush & ~rst & (hit_rs | (id_uses_rt & hit_rt));
  assign bubble = stall;

  // A stalled or flushed instruction does not advance, so it is not recorded.
  assign insert = id_valid & id_regwr & ~stall & ~flush & (id_aw != REG_ZERO);

  always_comb begin
    new_slot       = '0;
    new_slot.valid = insert;
    new_slot.addr  = insert ? id_aw : REG_ZERO;
  end

  // Slot shift register and stall counter (in-flight writes never stall).
  always_ff @(posedge clk) begin
    if (rst) begin
      slots        <= '0;
      stall_cycles <= '0;
    end else begin
      for (int i = 1; i < NUM_SLOTS; i++) begin
        slots[i] <= slots[i-1];
      end
      slots[0] <= new_slot;
      if (stall) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pending[i] = slots[i].valid;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by
// random traffic, compared against a timing-based reference model.
// A second instance with a 2-bit counter exercises saturation.
module tb_hazard_unit;

  localparam int NS = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_regwr;
  logic [4:0] id_aw;
  logic       flush;

  logic          stall_a, bubble_a, stall_b, bubble_b;
  logic [NS-1:0] pending_a, pending_b;
  logic [15:0]   cnt_a;
  logic [1:0]    cnt_b;

  always #5 clk = ~clk;

  hazard_unit #(.NUM_SLOTS(NS), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_regwr(id_regwr), .id_aw(id_aw), .flush(flush),
    .stall(stall_a), .bubble(bubble_a), .pending(pending_a), .stall_cycles(cnt_a)
  );

  hazard_unit #(.NUM_SLOTS(NS), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_regwr(id_regwr), .id_aw(id_aw), .flush(flush),
    .stall(stall_b), .bubble(bubble_b), .pending(pending_b), .stall_cycles(cnt_b)
  );

  int npass = 0;
  int nchk  = 0;

  // Reference model: a register is busy for NS cycles after the cycle in which
  // its youngest writer was accepted from ID; accepted-writer cycles drive pending.
  int last_issue[32];
  bit accepted[int];
  int t = 0;
  int m_cnt16 = 0;
  int m_cnt2  = 0;

  function automatic bit busy(input logic [4:0] r);
    int age;
    age = t - last_issue[r];
    return (r != 5'd0) && (age >= 1) && (age <= NS);
  endfunction

  function automatic bit exp_stall();
    return id_valid && !flush && !rst &&
           (busy(id_rs) || (id_uses_rt && busy(id_rt)));
  endfunction

  function automatic logic [NS-1:0] exp_pending();
    logic [NS-1:0] p;
    p = '0;
    for (int k = 0; k < NS; k++) begin
      p[k] = accepted.exists(t - 1 - k);
    end
    return p;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) last_issue[r] = -1000;
    accepted.delete();
    m_cnt16 = 0;
    m_cnt2  = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
  endtask

  // Check every output mid-cycle, then clock and advance the model.
  task automatic cycle(input string tag);
    bit s;
    #3;
    s = exp_stall();
    chk({tag, ".stall"},    {31'd0, stall_a},   {31'd0, s});
    chk({tag, ".bubble"},   {31'd0, bubble_a},  {31'd0, s});
    chk({tag, ".pending"},  {29'd0, pending_a}, {29'd0, exp_pending()});
    chk({tag, ".cnt16"},    {16'd0, cnt_a},     m_cnt16);
    chk({tag, ".stall_s"},  {31'd0, stall_b},   {31'd0, s});
    chk({tag, ".bubble_s"}, {31'd0, bubble_b},  {31'd0, s});
    chk({tag, ".pend_s"},   {29'd0, pending_b}, {29'd0, exp_pending()});
    chk({tag, ".cnt2"},     {30'd0, cnt_b},     m_cnt2);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (s) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (id_valid && id_regwr && !s && !flush && id_aw != 5'd0) begin
        last_issue[id_aw] = t;
        accepted[t] = 1'b1;
      end
    end
    t++;
    #1;
  endtask

  task automatic drive(input string tag, input bit v, input logic [4:0] rs,
                       input logic [4:0] rt, input bit urt, input bit wr,
                       input logic [4:0] aw, input bit fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_regwr = wr; id_aw = aw; flush = fl;
    cycle(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive("idle", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
    id_regwr = 1'b1; id_aw = 5'd3; flush = 1'b0;
    @(posedge clk);
    t++;
    #1;
    // Reset state with a would-be dependency on the inputs.
    drive("reset", 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0);
    chk("reset.pending", {29'd0, pending_a}, 32'd0);
    rst = 1'b0;

    // Back-to-back dependency: three stall cycles, then release.
    drive("b2b.prod", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    for (int i = 0; i < 4; i++) drive("b2b.cons", 1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("b2b.count", {16'd0, cnt_a}, 32'd3);
    idle(3);

    // Independent ops: pending walks 001 -> 010 -> 100 -> 000.
    drive("indep.prod", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    drive("indep.cons", 1'b1, 5'd4, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    idle(3);

    // $0 writer is never recorded and $0 reader never stalls.
    drive("zero.prod", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    drive("zero.cons", 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    idle(3);

    // rt dependency only counts when rt is actually read.
    drive("imm.prod", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    drive("imm.nort", 1'b1, 5'd2, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0);
    drive("imm.rt",   1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    idle(3);

    // Flush beats stall; the flushed writer is not inserted.
    drive("flush.prod", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
    drive("flush.cons", 1'b1, 5'd9, 5'd0, 1'b0, 1'b1, 5'd10, 1'b1);
    chk("flush.pending", {29'd0, pending_a}, 32'd2);
    idle(3);

    // Reset during the second stall cycle drops the dependency.
    drive("rst.prod", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    drive("rst.stall1", 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    rst = 1'b1;
    drive("rst.stall2", 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    rst = 1'b0;
    chk("rst.pending", {29'd0, pending_a}, 32'd0);
    chk("rst.count", {16'd0, cnt_a}, 32'd0);
    drive("rst.after", 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Six stall cycles: 2-bit counter must stick at 3.
    drive("sat.prod1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
    for (int i = 0; i < 4; i++) drive("sat.cons1", 1'b1, 5'd6, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    drive("sat.prod2", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
    for (int i = 0; i < 4; i++) drive("sat.cons2", 1'b1, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("sat.count2", {30'd0, cnt_b}, 32'd3);
    chk("sat.count16", {16'd0, cnt_a}, 32'd6);

    // Random traffic over a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive("rand",
            ($urandom_range(0, 7) != 0),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0));
    end
    rst = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter NUM_SLOTS, default 3, number of in-flight write stages tracked (EX, MEM, WB).
REQ-002 Parameter CNT_W, default 16, width of stall performance counter.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_rs  input  5  source register A of ID instruction.
REQ-007 id_rt  input  5  source register B of ID instruction.
REQ-008 id_uses_rt  input  1  ID instruction reads rt (R-type, sw); 0 for ALUsrc-immediate loads/addi.
REQ-009 id_regwr  input  1  ID instruction writes register file.
REQ-010 id_aw  input  5  destination address selected by RegDst in ID.
REQ-011 flush  input  1  kill ID instruction this cycle (jr / redirect).
REQ-012 stall  output  1  hold PC and IF/ID register.
REQ-013 bubble  output  1  zero RegWr/MemWr control bits entering ID/EX.
REQ-014 pending  output  NUM_SLOTS  valid bit per scoreboard slot, bit 0 = EX.
REQ-015 stall_cycles  output  CNT_W  saturating count of cycles with stall=1.

Function
REQ-016 Scoreboard holds NUM_SLOTS entries {valid, addr[4:0]}; slot 0 = EX, slot NUM_SLOTS-1 = WB.
REQ-017 Every cycle, not in reset: slot[i] <= slot[i-1] for i>=1, unconditionally (in-flight instructions never stall).
REQ-018 slot[0] <= {1, id_aw} when id_valid & id_regwr & ~stall & ~flush & (id_aw != 0); else {0, 0}.
REQ-019 Match(r) = (r != 0) & OR over slots of (slot.valid & slot.addr == r).
REQ-020 stall = id_valid & ~flush & ~rst & (Match(id_rs) | (id_uses_rt & Match(id_rt))); combinational, same cycle.
REQ-021 bubble = stall; a stalled ID instruction never enters the scoreboard (REQ-018).
REQ-022 Register file has no write-through bypass; WB-slot match stalls; maximum consecutive stall for one dependency = NUM_SLOTS cycles.
REQ-023 Register 0 never causes a stall and is never entered into the scoreboard.
REQ-024 flush has priority over stall: stall=0, bubble=0, no slot[0] insert that cycle; existing slots still shift.
REQ-025 Same address in several slots: any match stalls; stall releases only when the last (youngest) copy leaves WB.
REQ-026 id_valid=0: stall=0, bubble=0, slot[0] loads invalid.
REQ-027 stall_cycles increments by 1 each cycle stall=1; holds at 2^CNT_W-1 (no wrap).
REQ-028 pending = per-slot valid bits, registered (reflects current slot state).

Reset
REQ-029 While rst=1 at a rising edge: all slots cleared to {0,0}, stall_cycles <= 0.
REQ-030 While rst=1: stall=0, bubble=0 regardless of inputs; pending=0 from the first edge with rst=1.
REQ-031 Reset mid-stall drops all pending dependencies; first cycle after rst deasserts evaluates hazards against an empty scoreboard.

Structure
REQ-032 Shared package mips_pkg holds: REG_ADDR_W=5, REG_ZERO=5'd0, NUM_PIPE_SLOTS=3, and the typedef for a scoreboard slot {valid, addr}.
REQ-033 One sub-module, hazard_match: combinational compare of one register address against all slots, instantiated twice (rs, rt).
REQ-034 No other sub-modules; counter and shift logic in hazard_unit.

Verification
REQ-035 Back-to-back dependency: cycle0 addu $3 (aw=3), cycle1 ID rs=3 -> stall=1 for 3 cycles (slots EX, MEM, WB), stall=0 on 4th, stall_cycles=3.
REQ-036 Independent ops: aw=3 then rs=4, rt=5, uses_rt=1 -> stall never asserts, pending shifts 001->010->100->000.
REQ-037 $0 writes: id_aw=0, id_regwr=1, then rs=0 -> no insert (pending=000), stall=0.
REQ-038 Immediate consumer: aw=7, then rt=7 with id_uses_rt=0, rs=2 -> stall=0; same with id_uses_rt=1 -> stall=1.
REQ-039 Flush priority: dependent ID instruction with flush=1 -> stall=0, bubble=0, slot[0] invalid next cycle; older slots still shift.
REQ-040 Reset mid-stall and saturation: assert rst during 2nd stall cycle -> pending=000, stall=0, stall_cycles=0; with CNT_W=2, 5 stall cycles -> stall_cycles=3.
